// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that writes KGPRISC instruction memory and holds the CPU in reset
// Optional IMEM_LOADER_CHECKSUM_EN: a trailing XOR checksum byte must match before the CPU is released.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [23:0]         word_q, word_d;
  logic [1:0]          idx_q, idx_d;
  logic [ADDR_W:0]     cnt_q, cnt_d, cnt_inc;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic [15:0]         len_full;
  logic                xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA, S_ERR, S_CHK: in_ready = ~restart;
      default:                                   in_ready = 1'b0;
    endcase
  end

  assign xfer = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    word_d   = word_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    len_full = {len_q[15:8], in_byte};
    cnt_inc  = cnt_q + (ADDR_W+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d = chk_q;
    if (xfer && (state_q == S_LEN_HI || state_q == S_LEN_LO || state_q == S_DATA))
      chk_d = chk_q ^ in_byte;
`endif

    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_byte;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full == 16'd0)
            state_d = S_FINISH;
          else if (32'(len_full) > 32'(MAX_WORDS))
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = {word_q, in_byte};
            state_d = S_WRITE;
          end else begin
            word_d = {word_q[15:0], in_byte};
          end
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_inc;
        state_d = (32'(cnt_inc) == 32'(len_q)) ? S_FINISH : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer)
          state_d = (in_byte == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = state_q;
    endcase

    // Restart overrides every transition, including one into WRITE, so a partial word is never written.
    if (restart) begin
      state_d = S_LEN_HI;
      len_d   = '0;
      word_d  = '0;
      idx_d   = '0;
      cnt_d   = '0;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_d   = '0;
`endif
    end

    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    cpu_reset_d = ~done_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LEN_HI;
      len_q       <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = cnt_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that writes 32-bit instruction words into the KGPRISC instruction memory, word address 0 upward.
- The processor is the reader of instruction memory; this block is its writer.
- Holds the processor in reset through its own cpu_reset output until the image is fully written, then releases it.
- Sits between a host byte source (UART receiver or bench driver) and the instruction-memory write port.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, largest accepted image length in words; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- restart  input  1  synchronous pulse; aborts any load and re-arms.
- in_byte  input  8  incoming stream byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address being written.
- mem_wdata  output  32  instruction word being written.
- cpu_reset  output  1  active-high hold for KGPRISC reset.
- done  output  1  image loaded and processor released.
- err  output  1  load rejected.
- word_count  output  ADDR_W+1  number of words written so far.

Behaviour:
- Reset (reset=0, asynchronous) and restart=1 (synchronous, highest priority) both do the same thing:
  - state ← LEN_HI.
  - mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, length register=0, byte index=0.
  - done=0, err=0, cpu_reset=1.
- Handshake: a byte transfers when in_valid & in_ready are both high at a rising edge.
  - in_ready is combinational: high in LEN_HI, LEN_LO, DATA and ERR; low in WRITE and DONE; forced low while restart=1.
  - A byte presented while restart=1 is not consumed.
- Stream format:
  - 16-bit big-endian length N (words) first.
  - Then 4·N bytes, each word big-endian (first byte → bits 31:24).
- States and transitions:
  - LEN_HI: on transfer, length[15:8] ← byte; go to LEN_LO.
  - LEN_LO: on transfer, length[7:0] ← byte. Then:
    - N=0 → DONE.
    - N > MAX_WORDS → ERR.
    - otherwise → DATA.
  - DATA: each transfer shifts the byte into the word register and increments the 2-bit byte index. On the 4th byte (index wraps 3→0), go to WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_addr=word_count[ADDR_W-1:0], mem_wdata=assembled word.
    - word_count increments at the end of the cycle.
    - If the incremented count equals N → DONE; else → DATA.
  - DONE: done=1 and cpu_reset=0, both registered and asserted the cycle the state is entered. Stays until restart or reset.
  - ERR: err=1 and cpu_reset=1. Sinks and discards all bytes (in_ready=1). Stays until restart or reset.
- Throughput: at most 4 bytes per 5 cycles; mem_we is never asserted on consecutive cycles.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- cpu_reset is high in every state except DONE. The processor never runs on a partial image.
- restart during DATA: the partial word is dropped and no write is issued. Words already written stay in memory but are not trusted.
- word_count saturates by construction: it can never exceed N.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - One extra byte follows the last data byte: the XOR of all length and data bytes.
  - A new state CHK is entered from WRITE in place of DONE.
  - On the checksum transfer: match → DONE; mismatch → ERR.
  - For N=0 the checksum byte (XOR of the two length bytes) is still required.
- When undefined: no checksum byte; WRITE/LEN_LO go directly to DONE as above.

Test Plan:
- Reset/idle: hold reset=0, then release → cpu_reset=1, done=0, err=0, mem_we=0, in_ready=1, word_count=0.
- Two-word load: stream 00 02 12 34 56 78 9A BC DE F0 with in_valid held high.
  - mem_we pulses twice: addr 0 / data 0x12345678, then addr 1 / data 0x9ABCDEF0.
  - in_ready is low during each WRITE cycle.
  - Then done=1, cpu_reset=0, word_count=2.
- Zero length: stream 00 00 → DONE right after the second byte; mem_we never asserted.
- Oversize: stream 04 01 (1025 > 1024) → err=1, cpu_reset stays 1; following bytes are accepted and discarded with no writes.
- Abort: pulse restart after 00 03 AA BB → no write occurs, state back to LEN_HI.
  - A fresh stream 00 01 11 22 33 44 writes 0x11223344 at addr 0, then done=1.
- Stalls plus async reset: with in_valid toggling every other cycle, a one-word load completes with the same data.
  - Asserting reset mid-DATA clears outputs immediately, without waiting for a clock edge.
  - With IMEM_LOADER_CHECKSUM_EN: stream 00 01 01 02 03 04 with a wrong checksum byte 00 → err=1.
  - The same stream with checksum 05 → done=1.
